minimac_membus_arbiter: RTL and testbench
=========================================

# minimac_membus_arbiter

Three-way Wishbone arbiter sharing the single-port Ethernet packet RAM between the CPU data bus, the MAC receive DMA master (write-only) and the MAC transmit DMA master (read-only). It sits between the MAC's `wbrx`/`wbtx` masters, the CPU bridge and the RAM slave port. It grants one transfer at a time in round-robin order and guarantees forward progress with a per-transfer ack timeout.

## Interface
- `TIMEOUT`, 8'd255: cycles a granted transfer may wait for `mem_ack_i` before forced termination (1..255).
- `sys_clk` in 1: system clock, all logic on rising edge.
- `sys_rst` in 1: synchronous, active-high reset.
- `cpu_adr_i` in 32, `cpu_dat_i` in 32, `cpu_sel_i` in 4, `cpu_we_i` in 1, `cpu_cyc_i` in 1, `cpu_stb_i` in 1: CPU request.
- `cpu_dat_o` out 32, `cpu_ack_o` out 1, `cpu_err_o` out 1: CPU response.
- `rx_adr_i` in 32, `rx_dat_i` in 32, `rx_cyc_i` in 1, `rx_stb_i` in 1: RX DMA write request (WE=1, SEL=1111 implied).
- `rx_ack_o` out 1: RX response.
- `tx_adr_i` in 32, `tx_cyc_i` in 1, `tx_stb_i` in 1: TX DMA read request (WE=0, SEL=1111 implied).
- `tx_dat_o` out 32, `tx_ack_o` out 1: TX response.
- `mem_adr_o` out 32, `mem_dat_o` out 32, `mem_sel_o` out 4, `mem_we_o` out 1, `mem_cyc_o` out 1, `mem_stb_o` out 1: RAM request.
- `mem_dat_i` in 32, `mem_ack_i` in 1: RAM response.
- `grant_o` out 2: current owner (0 none, 1 cpu, 2 rx, 3 tx), registered.
- `timeout_o` out 1: one-cycle pulse on forced termination.

## Operation
- States: IDLE, BUSY. Registers: `state`, `owner[1:0]`, `last[1:0]`, `cnt[7:0]`.
- Request of master m = `m_cyc_i & m_stb_i`.
- IDLE: if any request, pick first requester scanning cyclically after `last` (order cpu -> rx -> tx -> cpu); next cycle state=BUSY, `owner`=pick, `cnt`=0. No request: stay IDLE.
- BUSY: `mem_adr_o/dat_o/sel_o/we_o` = owner's signals (rx: we=1, sel=4'hF; tx: we=0, sel=4'hF, dat_o=0); `mem_cyc_o`=owner cyc, `mem_stb_o`=owner stb. Combinational mux from registered owner.
- `mem_dat_i` drives `cpu_dat_o` and `tx_dat_o` unconditionally; acks gated: `m_ack_o = BUSY & owner==m & m_cyc & m_stb & mem_ack_i`.
- Transfer end (any of): ack forwarded; owner drops `cyc` (abort, nothing forwarded); timeout. On end: state=IDLE, `last`=owner, `owner`=0 at next edge.
- Timeout: `cnt` increments each BUSY cycle without ack; when `cnt == TIMEOUT-1` and no ack, terminate: cpu gets `cpu_err_o`=1 for that cycle; rx/tx get synthetic `m_ack_o`=1 (data discarded / `tx_dat_o`=mem_dat_i undefined); `timeout_o`=1; `mem_cyc_o`/`mem_stb_o` still asserted that cycle, dropped next.
- One transfer per grant: a master holding `cyc` across acks re-arbitrates each word.

## Timing
- Reset: state=IDLE, `owner`=0, `last`=3 (cpu first), `cnt`=0; `grant_o`=0, all `mem_*_o`, acks, `cpu_err_o`, `timeout_o` = 0; data outputs follow `mem_dat_i`.
- Arbitration latency: request in IDLE at cycle N -> `mem_stb_o` at N+1. Zero-wait RAM: ack at N+1, IDLE at N+2; back-to-back throughput one transfer per 2 cycles.
- Ack forwarding is combinational, same cycle as `mem_ack_i`.
- Ack and timeout in same cycle: ack wins, no `timeout_o`, no err.
- Ack with owner `cyc` dropped same cycle: ack not forwarded, treated as abort.
- `mem_ack_i` while IDLE or with stb low: ignored.
- Reset mid-transfer: outputs drop after the reset edge; no ack forwarded for the in-flight transfer; `last` reloads to 3.
- Masters must hold address/data/stb stable until ack (Wishbone classic); arbiter does not register request signals.

## Test plan
- Single CPU write adr=0x10 dat=0xDEADBEEF, RAM acks 1 cycle after stb -> `mem_we_o`=1, `mem_sel_o`=cpu_sel, `cpu_ack_o` one cycle, `grant_o` 1 -> 0, word readable back via TX read returning 0xDEADBEEF on `tx_dat_o`.
- All three request continuously from reset, zero-wait RAM -> grant sequence cpu, rx, tx, cpu, rx, tx; each ack only to owner; 2 cycles per transfer.
- RX and TX contend while CPU idle, `last`=rx -> TX granted first, then RX; rx writes carry `mem_sel_o`=4'hF, `mem_we_o`=1.
- TIMEOUT=4, RAM never acks CPU read -> `cpu_err_o` and `timeout_o` high exactly 4th BUSY cycle, `mem_cyc_o` low next cycle; repeat with TX -> `tx_ack_o` synthetic, no err.
- Ack on the timeout cycle -> normal ack, `timeout_o`=0; owner drops cyc mid-wait -> no ack, IDLE next cycle, next requester granted.
- Assert `sys_rst` during BUSY with RAM stalled -> next cycle `mem_cyc_o`=0, `grant_o`=0; after release CPU wins a three-way request.

Source files
------------

// File: rtl/minimac_membus_arbiter.sv
// ============================================================================
// minimac_membus_arbiter : round-robin Wishbone arbiter (CPU / RX DMA / TX DMA)
//                          onto the single-port packet RAM, with ack timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module minimac_membus_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        sys_clk,
  input  logic        sys_rst,

  input  logic [31:0] cpu_adr_i,
  input  logic [31:0] cpu_dat_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic        cpu_we_i,
  input  logic        cpu_cyc_i,
  input  logic        cpu_stb_i,
  output logic [31:0] cpu_dat_o,
  output logic        cpu_ack_o,
  output logic        cpu_err_o,

  input  logic [31:0] rx_adr_i,
  input  logic [31:0] rx_dat_i,
  input  logic        rx_cyc_i,
  input  logic        rx_stb_i,
  output logic        rx_ack_o,

  input  logic [31:0] tx_adr_i,
  input  logic        tx_cyc_i,
  input  logic        tx_stb_i,
  output logic [31:0] tx_dat_o,
  output logic        tx_ack_o,

  output logic [31:0] mem_adr_o,
  output logic [31:0] mem_dat_o,
  output logic [3:0]  mem_sel_o,
  output logic        mem_we_o,
  output logic        mem_cyc_o,
  output logic        mem_stb_o,
  input  logic [31:0] mem_dat_i,
  input  logic        mem_ack_i,

  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_BUSY = 1'b1;

  localparam logic [1:0] c_NONE = 2'd0;
  localparam logic [1:0] c_CPU  = 2'd1;
  localparam logic [1:0] c_RX   = 2'd2;
  localparam logic [1:0] c_TX   = 2'd3;

  localparam logic [7:0] c_CNT_LAST = TIMEOUT - 8'd1;

  logic [0:0] r_state;
  logic [1:0] r_owner;
  logic [1:0] r_last;
  logic [7:0] r_cnt;

  logic       w_req_cpu, w_req_rx, w_req_tx;
  logic [1:0] w_pick;
  logic       w_busy;
  logic       w_own_cyc, w_own_stb;
  logic       w_ack_fwd, w_abort, w_tmo, w_end;

  assign w_req_cpu = cpu_cyc_i & cpu_stb_i;
  assign w_req_rx  = rx_cyc_i  & rx_stb_i;
  assign w_req_tx  = tx_cyc_i  & tx_stb_i;
  assign w_busy    = (r_state == c_BUSY);

  // Scan starts at the master after the previous owner (cpu -> rx -> tx -> cpu).
  always_comb begin
    w_pick = c_NONE;
    case (r_last)
      c_CPU: begin
        if      (w_req_rx)  w_pick = c_RX;
        else if (w_req_tx)  w_pick = c_TX;
        else if (w_req_cpu) w_pick = c_CPU;
      end
      c_RX: begin
        if      (w_req_tx)  w_pick = c_TX;
        else if (w_req_cpu) w_pick = c_CPU;
        else if (w_req_rx)  w_pick = c_RX;
      end
      default: begin
        if      (w_req_cpu) w_pick = c_CPU;
        else if (w_req_rx)  w_pick = c_RX;
        else if (w_req_tx)  w_pick = c_TX;
      end
    endcase
  end

  always_comb begin
    mem_adr_o = 32'd0;
    mem_dat_o = 32'd0;
    mem_sel_o = 4'd0;
    mem_we_o  = 1'b0;
    w_own_cyc = 1'b0;
    w_own_stb = 1'b0;
    if (w_busy) begin
      case (r_owner)
        c_CPU: begin
          mem_adr_o = cpu_adr_i;
          mem_dat_o = cpu_dat_i;
          mem_sel_o = cpu_sel_i;
          mem_we_o  = cpu_we_i;
          w_own_cyc = cpu_cyc_i;
          w_own_stb = cpu_stb_i;
        end
        c_RX: begin
          mem_adr_o = rx_adr_i;
          mem_dat_o = rx_dat_i;
          mem_sel_o = 4'hF;
          mem_we_o  = 1'b1;
          w_own_cyc = rx_cyc_i;
          w_own_stb = rx_stb_i;
        end
        c_TX: begin
          mem_adr_o = tx_adr_i;
          mem_sel_o = 4'hF;
          w_own_cyc = tx_cyc_i;
          w_own_stb = tx_stb_i;
        end
        default: ;
      endcase
    end
  end

  // A real ack beats a timeout in the same cycle; a dropped cyc beats both.
  assign w_ack_fwd = w_busy & w_own_cyc & w_own_stb & mem_ack_i;
  assign w_abort   = w_busy & ~w_own_cyc;
  assign w_tmo     = w_busy & w_own_cyc & ~w_ack_fwd & (r_cnt == c_CNT_LAST);
  assign w_end     = w_ack_fwd | w_abort | w_tmo;

  assign mem_cyc_o = w_own_cyc;
  assign mem_stb_o = w_own_stb;

  assign cpu_dat_o = mem_dat_i;
  assign tx_dat_o  = mem_dat_i;

  assign cpu_ack_o = (r_owner == c_CPU) & w_ack_fwd;
  assign cpu_err_o = (r_owner == c_CPU) & w_tmo;
  assign rx_ack_o  = (r_owner == c_RX)  & (w_ack_fwd | w_tmo);
  assign tx_ack_o  = (r_owner == c_TX)  & (w_ack_fwd | w_tmo);
  assign timeout_o = w_tmo;
  assign grant_o   = r_owner;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= c_IDLE;
      r_owner <= c_NONE;
      r_last  <= c_TX;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_pick != c_NONE) begin
            r_state <= c_BUSY;
            r_owner <= w_pick;
            r_cnt   <= 8'd0;
          end
        end
        default: begin
          if (w_end) begin
            r_state <= c_IDLE;
            r_last  <= r_owner;
            r_owner <= c_NONE;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_minimac_membus_arbiter.sv
// ============================================================================
// tb_minimac_membus_arbiter : directed bench for the packet-RAM arbiter with a
//                             small byte-enabled RAM model and selectable ack.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_minimac_membus_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [31:0] cpu_adr_i, cpu_dat_i;
  logic [3:0]  cpu_sel_i;
  logic        cpu_we_i, cpu_cyc_i, cpu_stb_i;
  logic [31:0] cpu_dat_o;
  logic        cpu_ack_o, cpu_err_o;
  logic [31:0] rx_adr_i, rx_dat_i;
  logic        rx_cyc_i, rx_stb_i, rx_ack_o;
  logic [31:0] tx_adr_i;
  logic        tx_cyc_i, tx_stb_i;
  logic [31:0] tx_dat_o;
  logic        tx_ack_o;
  logic [31:0] mem_adr_o, mem_dat_o, mem_dat_i;
  logic [3:0]  mem_sel_o;
  logic        mem_we_o, mem_cyc_o, mem_stb_o, mem_ack_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  int n_checks = 0;
  int n_errors = 0;

  // 0: zero-wait, 1: ack one cycle after stb, 2: never, 3: manual ack_force
  logic [1:0]  ack_mode;
  logic        ack_force;
  logic        ack_d;
  logic [31:0] ram [0:15];

  always #5 sys_clk = ~sys_clk;

  minimac_membus_arbiter #(.TIMEOUT(8'd4)) u_dut (
    .sys_clk   (sys_clk),   .sys_rst   (sys_rst),
    .cpu_adr_i (cpu_adr_i), .cpu_dat_i (cpu_dat_i), .cpu_sel_i (cpu_sel_i),
    .cpu_we_i  (cpu_we_i),  .cpu_cyc_i (cpu_cyc_i), .cpu_stb_i (cpu_stb_i),
    .cpu_dat_o (cpu_dat_o), .cpu_ack_o (cpu_ack_o), .cpu_err_o (cpu_err_o),
    .rx_adr_i  (rx_adr_i),  .rx_dat_i  (rx_dat_i),  .rx_cyc_i  (rx_cyc_i),
    .rx_stb_i  (rx_stb_i),  .rx_ack_o  (rx_ack_o),
    .tx_adr_i  (tx_adr_i),  .tx_cyc_i  (tx_cyc_i),  .tx_stb_i  (tx_stb_i),
    .tx_dat_o  (tx_dat_o),  .tx_ack_o  (tx_ack_o),
    .mem_adr_o (mem_adr_o), .mem_dat_o (mem_dat_o), .mem_sel_o (mem_sel_o),
    .mem_we_o  (mem_we_o),  .mem_cyc_o (mem_cyc_o), .mem_stb_o (mem_stb_o),
    .mem_dat_i (mem_dat_i), .mem_ack_i (mem_ack_i),
    .grant_o   (grant_o),   .timeout_o (timeout_o)
  );

  assign mem_dat_i = ram[mem_adr_o[5:2]];
  assign mem_ack_i = (ack_mode == 2'd0) ? (mem_cyc_o & mem_stb_o) :
                     (ack_mode == 2'd1) ? ack_d :
                     (ack_mode == 2'd3) ? ack_force : 1'b0;

  always @(posedge sys_clk) begin
    ack_d <= mem_cyc_o & mem_stb_o & ~mem_ack_i & ~sys_rst;
    if (mem_cyc_o & mem_stb_o & mem_we_o & mem_ack_i) begin
      for (int b = 0; b < 4; b++)
        if (mem_sel_o[b]) ram[mem_adr_o[5:2]][8*b +: 8] <= mem_dat_o[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic smp();
    #3;
  endtask

  task automatic idle_all();
    cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0;
    rx_cyc_i  = 1'b0; rx_stb_i  = 1'b0;
    tx_cyc_i  = 1'b0; tx_stb_i  = 1'b0;
  endtask

  function automatic logic [2:0] ack_vec(input logic [1:0] own);
    case (own)
      2'd1:    return 3'b100;
      2'd2:    return 3'b010;
      2'd3:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  logic [1:0] exp_grant [0:5];

  initial begin
    exp_grant[0] = 2'd1; exp_grant[1] = 2'd2; exp_grant[2] = 2'd3;
    exp_grant[3] = 2'd1; exp_grant[4] = 2'd2; exp_grant[5] = 2'd3;

    sys_rst = 1'b1;
    ack_mode = 2'd0; ack_force = 1'b0;
    cpu_adr_i = '0; cpu_dat_i = '0; cpu_sel_i = 4'hF; cpu_we_i = 1'b0;
    rx_adr_i = '0; rx_dat_i = '0; tx_adr_i = '0;
    idle_all();
    nxt(); nxt();
    sys_rst = 1'b0;
    smp();
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_cyc",   32'(mem_cyc_o), 32'd0);
    chk("rst_stb",   32'(mem_stb_o), 32'd0);
    chk("rst_resp",  32'({cpu_ack_o, rx_ack_o, tx_ack_o, cpu_err_o, timeout_o}), 32'd0);

    // CPU write, RAM acks one cycle after stb
    ack_mode = 2'd1;
    nxt();
    cpu_adr_i = 32'h10; cpu_dat_i = 32'hDEADBEEF; cpu_sel_i = 4'hF; cpu_we_i = 1'b1;
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1;
    smp();
    chk("wr_idle_stb", 32'(mem_stb_o), 32'd0);
    nxt(); smp();
    chk("wr_grant", 32'(grant_o), 32'd1);
    chk("wr_stb",   32'(mem_stb_o), 32'd1);
    chk("wr_we",    32'(mem_we_o), 32'd1);
    chk("wr_sel",   32'(mem_sel_o), 32'hF);
    chk("wr_adr",   mem_adr_o, 32'h10);
    chk("wr_dat",   mem_dat_o, 32'hDEADBEEF);
    chk("wr_noack", 32'(cpu_ack_o), 32'd0);
    nxt(); smp();
    chk("wr_ack",   32'(cpu_ack_o), 32'd1);
    nxt();
    idle_all();
    smp();
    chk("wr_done_grant", 32'(grant_o), 32'd0);
    chk("wr_done_ack",   32'(cpu_ack_o), 32'd0);

    // TX read-back; last=cpu so tx is reached after rx
    tx_adr_i = 32'h10; tx_cyc_i = 1'b1; tx_stb_i = 1'b1;
    nxt(); smp();
    chk("rd_grant", 32'(grant_o), 32'd3);
    chk("rd_we",    32'(mem_we_o), 32'd0);
    chk("rd_sel",   32'(mem_sel_o), 32'hF);
    chk("rd_dato",  mem_dat_o, 32'd0);
    nxt(); smp();
    chk("rd_ack",   32'(tx_ack_o), 32'd1);
    chk("rd_data",  tx_dat_o, 32'hDEADBEEF);
    nxt();
    idle_all();

    // Three masters requesting continuously, zero-wait RAM
    ack_mode = 2'd0;
    cpu_we_i = 1'b0; cpu_adr_i = 32'h10;
    rx_adr_i = 32'h20; rx_dat_i = 32'h11111111;
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1;
    rx_cyc_i  = 1'b1; rx_stb_i  = 1'b1;
    tx_cyc_i  = 1'b1; tx_stb_i  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nxt(); smp();
      chk($sformatf("rr_grant%0d", i), 32'(grant_o), 32'(exp_grant[i]));
      chk($sformatf("rr_acks%0d", i), 32'({cpu_ack_o, rx_ack_o, tx_ack_o}),
          32'(ack_vec(exp_grant[i])));
      nxt(); smp();
      chk($sformatf("rr_gap%0d", i), 32'(grant_o), 32'd0);
    end
    idle_all();

    // RX/TX contention with last=rx
    rx_adr_i = 32'h24; rx_dat_i = 32'hA5A5A5A5; rx_cyc_i = 1'b1; rx_stb_i = 1'b1;
    nxt(); smp();
    chk("rx_grant", 32'(grant_o), 32'd2);
    chk("rx_ack",   32'(rx_ack_o), 32'd1);
    chk("rx_dat",   mem_dat_o, 32'hA5A5A5A5);
    tx_cyc_i = 1'b1; tx_stb_i = 1'b1;
    nxt(); smp();
    chk("ct_idle", 32'(grant_o), 32'd0);
    nxt(); smp();
    chk("ct_first_tx", 32'(grant_o), 32'd3);
    chk("ct_tx_acks",  32'({cpu_ack_o, rx_ack_o, tx_ack_o}), 32'b001);
    nxt(); nxt(); smp();
    chk("ct_then_rx", 32'(grant_o), 32'd2);
    chk("ct_rx_sel",  32'(mem_sel_o), 32'hF);
    chk("ct_rx_we",   32'(mem_we_o), 32'd1);
    chk("ct_rx_acks", 32'({cpu_ack_o, rx_ack_o, tx_ack_o}), 32'b010);
    idle_all();
    nxt();

    // CPU timeout, RAM never acks; last=rx so cpu comes after tx
    ack_mode = 2'd2;
    cpu_we_i = 1'b0; cpu_sel_i = 4'h6; cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1;
    nxt(); smp();
    chk("to_grant", 32'(grant_o), 32'd1);
    chk("to_sel",   32'(mem_sel_o), 32'h6);
    chk("to_c1",    32'({cpu_err_o, timeout_o}), 32'd0);
    nxt(); nxt(); smp();
    chk("to_c3",    32'({cpu_err_o, timeout_o}), 32'd0);
    nxt(); smp();
    chk("to_err",   32'(cpu_err_o), 32'd1);
    chk("to_pulse", 32'(timeout_o), 32'd1);
    chk("to_noack", 32'(cpu_ack_o), 32'd0);
    chk("to_cyc",   32'({mem_cyc_o, mem_stb_o}), 32'b11);
    idle_all();
    nxt(); smp();
    chk("to_after_cyc",   32'(mem_cyc_o), 32'd0);
    chk("to_after_grant", 32'(grant_o), 32'd0);
    chk("to_after_pulse", 32'({cpu_err_o, timeout_o}), 32'd0);

    // TX timeout: synthetic ack, no err
    tx_cyc_i = 1'b1; tx_stb_i = 1'b1;
    nxt(); nxt(); nxt(); smp();
    chk("tto_c3", 32'(tx_ack_o), 32'd0);
    nxt(); smp();
    chk("tto_ack",   32'(tx_ack_o), 32'd1);
    chk("tto_pulse", 32'(timeout_o), 32'd1);
    chk("tto_noerr", 32'(cpu_err_o), 32'd0);
    idle_all();
    nxt(); smp();
    chk("tto_after_cyc", 32'(mem_cyc_o), 32'd0);

    // Ack arriving on the timeout cycle wins
    ack_mode = 2'd3; ack_force = 1'b0;
    cpu_sel_i = 4'hF; cpu_adr_i = 32'h10; cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1;
    nxt(); nxt(); nxt(); nxt();
    ack_force = 1'b1;
    smp();
    chk("lat_grant", 32'(grant_o), 32'd1);
    chk("lat_ack",   32'(cpu_ack_o), 32'd1);
    chk("lat_noto",  32'({cpu_err_o, timeout_o}), 32'd0);
    chk("lat_data",  cpu_dat_o, 32'hDEADBEEF);
    idle_all();
    ack_force = 1'b0;
    nxt(); smp();
    chk("lat_idle", 32'(grant_o), 32'd0);

    // Abort: rx drops cyc while acked; cpu then granted
    rx_cyc_i = 1'b1; rx_stb_i = 1'b1; cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1;
    nxt(); smp();
    chk("ab_grant", 32'(grant_o), 32'd2);
    nxt();
    rx_cyc_i = 1'b0; rx_stb_i = 1'b0; ack_force = 1'b1;
    smp();
    chk("ab_noack", 32'(rx_ack_o), 32'd0);
    chk("ab_noto",  32'(timeout_o), 32'd0);
    chk("ab_cyc",   32'(mem_cyc_o), 32'd0);
    nxt(); smp();
    chk("ab_idle",      32'(grant_o), 32'd0);
    chk("ab_idle_ack",  32'(cpu_ack_o), 32'd0);
    nxt(); smp();
    chk("ab_next_grant", 32'(grant_o), 32'd1);
    chk("ab_next_ack",   32'(cpu_ack_o), 32'd1);
    idle_all();
    ack_force = 1'b0;
    nxt();

    // Reset during a stalled CPU transfer
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1;
    nxt(); smp();
    chk("rs_grant", 32'(grant_o), 32'd1);
    nxt();
    sys_rst = 1'b1;
    rx_cyc_i = 1'b1; rx_stb_i = 1'b1; tx_cyc_i = 1'b1; tx_stb_i = 1'b1;
    smp();
    chk("rs_noack", 32'(cpu_ack_o), 32'd0);
    nxt();
    sys_rst = 1'b0;
    smp();
    chk("rs_cyc",   32'(mem_cyc_o), 32'd0);
    chk("rs_grant0", 32'(grant_o), 32'd0);
    nxt();
    ack_force = 1'b1;
    smp();
    chk("rs_cpu_wins", 32'(grant_o), 32'd1);
    chk("rs_cpu_ack",  32'({cpu_ack_o, rx_ack_o, tx_ack_o}), 32'b100);
    idle_all();
    ack_force = 1'b0;
    nxt();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
